// File: rtl/mem_arb_pkg.sv
// Shared types for the 2:1 memory arbiter: port IDs and memory message payloads.
package mem_arb_pkg;

    localparam int unsigned MEM_TYPE_W   = 3;
    localparam int unsigned MEM_OPAQUE_W = 8;
    localparam int unsigned MEM_ADDR_W   = 32;
    localparam int unsigned MEM_LEN_W    = 2;
    localparam int unsigned MEM_DATA_W   = 32;
    localparam int unsigned MEM_TEST_W   = 2;

    localparam logic [MEM_TYPE_W-1:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [MEM_TYPE_W-1:0] MEM_TYPE_WRITE = 3'd1;

    // Requester identity carried in the tag FIFO
    typedef logic port_id_t;

    localparam port_id_t PORT_IMEM = 1'b0;
    localparam port_id_t PORT_DMEM = 1'b1;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   typ;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   typ;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_TEST_W-1:0]   test;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_resp_4B_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of 1-bit grant IDs, one entry per outstanding memory request.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  port_id_t push_tag,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output port_id_t head
);

    // A depth of 1 still gets a 1-bit pointer; the count alone limits occupancy
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SLOTS = 2 ** PTR_W;

    logic [SLOTS-1:0] tags;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = tags[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer, count and storage update; pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arb_2to1.sv
// Shares one memory port between instruction fetch (port 0) and data (port 1),
// routing in-order responses back by the tag recorded at request acceptance.
module mem_arb_2to1
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          FIXED_PRIO      = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,

    input  mem_req_4B_t  req0_msg,
    input  logic         req0_val,
    output logic         req0_rdy,
    input  mem_req_4B_t  req1_msg,
    input  logic         req1_val,
    output logic         req1_rdy,

    output mem_resp_4B_t resp0_msg,
    output logic         resp0_val,
    input  logic         resp0_rdy,
    output mem_resp_4B_t resp1_msg,
    output logic         resp1_val,
    input  logic         resp1_rdy,

    output mem_req_4B_t  mem_req_msg,
    output logic         mem_req_val,
    input  logic         mem_req_rdy,

    input  mem_resp_4B_t mem_resp_msg,
    input  logic         mem_resp_val,
    output logic         mem_resp_rdy
);

    logic     fifo_full;
    logic     fifo_empty;
    port_id_t head_tag;
    port_id_t gnt;
    logic     gnt_val;
    logic     locked;
    port_id_t lock_gnt;
    port_id_t last_gnt;
    logic     req_fire;
    logic     resp_fire;
    logic     route_val;

    // Grant selection: a stalled grant is held, otherwise arbitrate among valid ports
    always_comb begin
        gnt     = PORT_IMEM;
        gnt_val = 1'b0;
        if (locked) begin
            gnt     = lock_gnt;
            gnt_val = (lock_gnt == PORT_DMEM) ? req1_val : req0_val;
        end else if (!fifo_full) begin
            if (req0_val && req1_val) begin
                gnt_val = 1'b1;
                gnt     = FIXED_PRIO ? PORT_DMEM : port_id_t'(~last_gnt);
            end else if (req0_val) begin
                gnt_val = 1'b1;
                gnt     = PORT_IMEM;
            end else if (req1_val) begin
                gnt_val = 1'b1;
                gnt     = PORT_DMEM;
            end
        end
    end

    // Request path: zero-latency pass-through of the granted port
    assign mem_req_val = rst_n & gnt_val;
    assign mem_req_msg = (gnt == PORT_DMEM) ? req1_msg : req0_msg;
    assign req0_rdy    = mem_req_val & (gnt == PORT_IMEM) & mem_req_rdy;
    assign req1_rdy    = mem_req_val & (gnt == PORT_DMEM) & mem_req_rdy;
    assign req_fire    = mem_req_val & mem_req_rdy;

    // Response path: head tag steers the memory response to its originator
    assign route_val    = rst_n & mem_resp_val & ~fifo_empty;
    assign resp0_val    = route_val & (head_tag == PORT_IMEM);
    assign resp1_val    = route_val & (head_tag == PORT_DMEM);
    assign resp0_msg    = mem_resp_msg;
    assign resp1_msg    = mem_resp_msg;
    assign mem_resp_rdy = rst_n & ~fifo_empty &
                          ((head_tag == PORT_DMEM) ? resp1_rdy : resp0_rdy);
    assign resp_fire    = mem_resp_val & mem_resp_rdy;

    // Lock holds a grant the memory did not take; last_gnt moves only on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            lock_gnt <= PORT_IMEM;
            last_gnt <= PORT_DMEM;
        end else begin
            locked   <= mem_req_val & ~mem_req_rdy;
            lock_gnt <= gnt;
            if (req_fire) begin
                last_gnt <= gnt;
            end
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH    (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_fire),
        .push_tag (gnt),
        .pop      (resp_fire),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_tag)
    );

    // A memory response with no outstanding request is a protocol error
    resp_needs_tag: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(mem_resp_val && fifo_empty));

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Directed and randomized checks of mem_arb_2to1 against a queue-based model.
module tb_mem_arb_2to1;
    import mem_arb_pkg::*;

    localparam int unsigned MO = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    mem_req_4B_t  req0_msg, req1_msg, mem_req_msg, b_mem_req_msg;
    logic         req0_val, req1_val, req0_rdy, req1_rdy;
    mem_resp_4B_t resp0_msg, resp1_msg, mem_resp_msg;
    logic         resp0_val, resp1_val, resp0_rdy, resp1_rdy;
    logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic         b_req0_rdy, b_req1_rdy, b_resp0_val, b_resp1_val;
    mem_resp_4B_t b_resp0_msg, b_resp1_msg;
    logic         b_mem_req_val, b_mem_resp_rdy;
    logic         b_mem_resp_val = 1'b0;
    mem_resp_4B_t b_mem_resp_msg = '0;

    always #5 clk = ~clk;

    mem_arb_2to1 #(.MAX_OUTSTANDING(MO), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy)
    );

    // Fixed-priority instance; its memory never answers
    mem_arb_2to1 #(.MAX_OUTSTANDING(4), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(b_req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(b_req1_rdy),
        .resp0_msg(b_resp0_msg), .resp0_val(b_resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(b_resp1_msg), .resp1_val(b_resp1_val), .resp1_rdy(resp1_rdy),
        .mem_req_msg(b_mem_req_msg), .mem_req_val(b_mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_resp_msg(b_mem_resp_msg), .mem_resp_val(b_mem_resp_val), .mem_resp_rdy(b_mem_resp_rdy)
    );

    // Reference model state
    bit           tags[$];
    mem_resp_4B_t memq[$];
    logic [31:0]  expq0[$];
    logic [31:0]  expq1[$];
    bit           stalled, stalled_port, last_winner;
    bit           mem_en, rand_mode, allow_new;
    bit           e_gv, e_gp, e_req_fire, e_resp_fire, e_have, e_head;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h10) return 32'hDEADBEEF;
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    function automatic mem_req_4B_t new_req();
        mem_req_4B_t r;
        r.typ    = MEM_TYPE_READ;
        r.opaque = 8'($urandom);
        r.addr   = 32'($urandom_range(0, 63)) << 2;
        r.len    = 2'd0;
        r.data   = 32'd0;
        return r;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input mem_req_4B_t r);
        mem_resp_4B_t s;
        s.typ    = r.typ;
        s.opaque = r.opaque;
        s.test   = 2'd0;
        s.len    = r.len;
        s.data   = mem_data(r.addr);
        return s;
    endfunction

    task automatic model_reset();
        tags.delete();
        memq.delete();
        expq0.delete();
        expq1.delete();
        stalled      = 1'b0;
        stalled_port = 1'b0;
        last_winner  = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req_val"},  128'(mem_req_val),   128'(0));
        chk({tag, "_req0_rdy"},     128'(req0_rdy),      128'(0));
        chk({tag, "_req1_rdy"},     128'(req1_rdy),      128'(0));
        chk({tag, "_resp0_val"},    128'(resp0_val),     128'(0));
        chk({tag, "_resp1_val"},    128'(resp1_val),     128'(0));
        chk({tag, "_mem_resp_rdy"}, 128'(mem_resp_rdy),  128'(0));
        chk({tag, "_fp_req_val"},   128'(b_mem_req_val), 128'(0));
    endtask

    // Memory presents its head response, then the model predicts and checks outputs
    task automatic cyc_pre();
        logic [31:0] want;
        mem_resp_val = mem_en && (memq.size() > 0);
        mem_resp_msg = (memq.size() > 0) ? memq[0] : '0;
        #1;
        e_gv = 1'b0;
        e_gp = 1'b0;
        if (stalled) begin
            e_gp = stalled_port;
            e_gv = e_gp ? req1_val : req0_val;
        end else if (tags.size() < MO) begin
            if (req0_val && req1_val) begin
                e_gv = 1'b1;
                e_gp = !last_winner;
            end else if (req0_val || req1_val) begin
                e_gv = 1'b1;
                e_gp = req1_val;
            end
        end
        e_req_fire  = e_gv && mem_req_rdy;
        e_have      = tags.size() > 0;
        e_head      = e_have ? tags[0] : 1'b0;
        e_resp_fire = mem_resp_val && e_have && (e_head ? resp1_rdy : resp0_rdy);

        chk("mem_req_val", 128'(mem_req_val), 128'(e_gv));
        chk("req0_rdy", 128'(req0_rdy), 128'(e_req_fire && !e_gp));
        chk("req1_rdy", 128'(req1_rdy), 128'(e_req_fire && e_gp));
        if (e_gv) chk("mem_req_msg", 128'(mem_req_msg), e_gp ? 128'(req1_msg) : 128'(req0_msg));
        chk("resp0_val", 128'(resp0_val), 128'(mem_resp_val && e_have && !e_head));
        chk("resp1_val", 128'(resp1_val), 128'(mem_resp_val && e_have && e_head));
        chk("mem_resp_rdy", 128'(mem_resp_rdy), 128'(e_have && (e_head ? resp1_rdy : resp0_rdy)));
        if (e_resp_fire) begin
            want = e_head ? expq1.pop_front() : expq0.pop_front();
            chk(e_head ? "resp1_data" : "resp0_data",
                128'(e_head ? resp1_msg.data : resp0_msg.data), 128'(want));
        end
    endtask

    // Clock edge: advance the model, then requesters/memory move at the falling edge
    task automatic cyc_post();
        @(posedge clk);
        if (e_resp_fire) begin
            void'(tags.pop_front());
            void'(memq.pop_front());
        end
        if (e_req_fire) begin
            tags.push_back(e_gp);
            memq.push_back(mk_resp(e_gp ? req1_msg : req0_msg));
            if (e_gp) expq1.push_back(mem_data(req1_msg.addr));
            else      expq0.push_back(mem_data(req0_msg.addr));
            last_winner = e_gp;
            stalled     = 1'b0;
        end else begin
            stalled      = e_gv;
            stalled_port = e_gp;
        end
        @(negedge clk);
        if (e_req_fire && !e_gp) req0_msg = new_req();
        if (e_req_fire &&  e_gp) req1_msg = new_req();
        if (rand_mode) begin
            if (e_req_fire && !e_gp)       req0_val = allow_new && ($urandom_range(0, 1) == 1);
            else if (!req0_val && allow_new) req0_val = ($urandom_range(0, 2) != 0);
            if (e_req_fire && e_gp)        req1_val = allow_new && ($urandom_range(0, 1) == 1);
            else if (!req1_val && allow_new) req1_val = ($urandom_range(0, 2) != 0);
            mem_req_rdy = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_en      = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
            resp0_rdy   = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
            resp1_rdy   = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_pre();
            cyc_post();
        end
    endtask

    initial begin
        mem_req_4B_t saved;
        rst_n        = 1'b0;
        req0_msg     = new_req();
        req1_msg     = new_req();
        req0_val     = 1'b1;
        req1_val     = 1'b1;
        resp0_rdy    = 1'b1;
        resp1_rdy    = 1'b1;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
        mem_en       = 1'b1;
        rand_mode    = 1'b0;
        allow_new    = 1'b0;
        model_reset();
        #1;
        chk_zero("rst_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both ports valid: round-robin alternates from port 0; fixed priority always port 1
        for (int i = 0; i < 4; i++) begin
            cyc_pre();
            chk($sformatf("rr_gnt%0d_req0_rdy", i), 128'(req0_rdy), 128'(i % 2 == 0));
            chk($sformatf("fp_gnt%0d_req1_rdy", i), 128'(b_req1_rdy), 128'(1));
            chk($sformatf("fp_gnt%0d_req0_rdy", i), 128'(b_req0_rdy), 128'(0));
            if (i > 0) chk($sformatf("rr_resp%0d_port0", i), 128'(resp0_val), 128'(i % 2 == 1));
            cyc_post();
        end
        req0_val = 1'b0;
        req1_val = 1'b0;
        cyc_pre();
        chk("rr_last_resp_port1", 128'(resp1_val), 128'(1));
        cyc_post();
        run(2);

        // Single port-0 read of 0x10 answered the next cycle
        req0_msg      = new_req();
        req0_msg.addr = 32'h10;
        req0_val      = 1'b1;
        cyc_pre();
        chk("single_req0_rdy", 128'(req0_rdy), 128'(1));
        cyc_post();
        req0_val = 1'b0;
        cyc_pre();
        chk("single_resp0_val", 128'(resp0_val), 128'(1));
        chk("single_resp0_data", 128'(resp0_msg.data), 128'(32'hDEADBEEF));
        chk("single_resp1_val", 128'(resp1_val), 128'(0));
        cyc_post();
        run(2);

        // Stalled grant to port 1 holds its message while port 0 rises
        req1_val    = 1'b1;
        mem_req_rdy = 1'b0;
        saved       = req1_msg;
        cyc_pre();
        chk("stall0_msg", 128'(mem_req_msg), 128'(saved));
        cyc_post();
        req0_val = 1'b1;
        cyc_pre();
        chk("stall1_msg", 128'(mem_req_msg), 128'(saved));
        chk("stall1_req0_rdy", 128'(req0_rdy), 128'(0));
        cyc_post();
        mem_req_rdy = 1'b1;
        cyc_pre();
        chk("stall_rel_req1_rdy", 128'(req1_rdy), 128'(1));
        chk("stall_rel_req0_rdy", 128'(req0_rdy), 128'(0));
        chk("stall_rel_msg", 128'(mem_req_msg), 128'(saved));
        cyc_post();
        req1_val = 1'b0;
        cyc_pre();
        chk("stall_next_req0_rdy", 128'(req0_rdy), 128'(1));
        cyc_post();
        req0_val = 1'b0;
        run(3);

        // Tag FIFO full: third request waits; a pop frees a slot only the next cycle
        mem_en   = 1'b0;
        req0_val = 1'b1;
        run(2);
        cyc_pre();
        chk("full_req0_rdy", 128'(req0_rdy), 128'(0));
        chk("full_mem_req_val", 128'(mem_req_val), 128'(0));
        cyc_post();
        mem_en = 1'b1;
        cyc_pre();
        chk("full_pop_resp_rdy", 128'(mem_resp_rdy), 128'(1));
        chk("full_pop_same_cycle", 128'(req0_rdy), 128'(0));
        cyc_post();
        cyc_pre();
        chk("full_after_pop", 128'(req0_rdy), 128'(1));
        cyc_post();
        req0_val = 1'b0;
        run(4);

        // Reset with two requests outstanding
        mem_en   = 1'b0;
        req0_val = 1'b1;
        run(2);
        req1_val = 1'b1;
        rst_n    = 1'b0;
        model_reset();
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst_n  = 1'b1;
        mem_en = 1'b1;
        cyc_pre();
        chk("rst_tie_req0_rdy", 128'(req0_rdy), 128'(1));
        chk("rst_empty_resp_rdy", 128'(mem_resp_rdy), 128'(0));
        cyc_post();
        req0_val = 1'b0;
        req1_val = 1'b0;
        run(3);

        // Randomized traffic, then drain without new requests
        rand_mode = 1'b1;
        allow_new = 1'b1;
        run(400);
        allow_new = 1'b0;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
